// File: rtl/dram_pkg.sv
// dram_pkg: FSM state encoding, width helpers and CPU address field positions for dram_controller_banked
package dram_pkg;
  typedef enum logic [2:0] {IDLE, ROW, COL, ACK, REF_CAS, REF_RAS, PRE} state_e;
  localparam int COL_LSB = 1;
  function automatic int bank_w(input int banks);
    return banks > 1 ? $clog2(banks) : 1;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int row_lsb(input int ma_w);
    return ma_w + 1;
  endfunction
  function automatic int bank_lsb(input int ma_w);
    return 2 * ma_w + 1;
  endfunction
endpackage

// File: rtl/dram_refresh_timer.sv
// dram_refresh_timer: free-running refresh interval timer; CLK/RST in, ack clears the request, pending out (single-deep, includes the wrapping cycle)
module dram_refresh_timer
  import dram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 300
) (
  input  logic CLK,
  input  logic RST,
  input  logic ack,
  output logic pending
);
  localparam int CW = cnt_w(REFRESH_INTERVAL);
  logic [CW-1:0] cnt_q;
  logic          pend_q;
  logic          wrap;
  assign wrap    = cnt_q == CW'(REFRESH_INTERVAL - 1);
  assign pending = pend_q | wrap;
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= wrap ? '0 : cnt_q + 1'b1;
      pend_q <= pending & ~ack;
    end
  end
endmodule

// File: rtl/dram_controller_banked.sv
// dram_controller_banked: banked 68000 DRAM controller with CBR refresh; CPU CS/AS/UDS/LDS/RW/ADDR_IN in, registered ADDR_OUT/RAS/CAS0/CAS1/WE to DRAM, DTACK_DRAM/REFRESH_BUSY out
module dram_controller_banked
  import dram_pkg::*;
#(
  parameter int ADDR_W           = 23,
  parameter int MA_W             = 11,
  parameter int BANKS            = 2,
  parameter int REFRESH_INTERVAL = 300,
  parameter int RAS_CYCLES       = 2,
  parameter int PRECHARGE_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              AS,
  input  logic              UDS,
  input  logic              LDS,
  input  logic              RW,
  input  logic [ADDR_W:1]   ADDR_IN,
  output logic [MA_W-1:0]   ADDR_OUT,
  output logic [BANKS-1:0]  RAS,
  output logic              CAS0,
  output logic              CAS1,
  output logic              WE,
  output logic              DTACK_DRAM,
  output logic              REFRESH_BUSY
);
  localparam int BANK_W   = bank_w(BANKS);
  localparam int CNT_W    = cnt_w(RAS_CYCLES > PRECHARGE_CYCLES ? RAS_CYCLES : PRECHARGE_CYCLES);
  localparam int ROW_LSB  = row_lsb(MA_W);
  localparam int BANK_LSB = bank_lsb(MA_W);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BANK_W-1:0] bank_q, bank_d, bank_in;
  logic [MA_W-1:0]   row_q, row_d, col_q, col_d, addr_q, addr_d;
  logic [BANKS-1:0]  ras_q, ras_d;
  logic              rw_q, rw_d, cas0_q, cas0_d, cas1_q, cas1_d;
  logic              we_q, we_d, dtack_q, dtack_d, busy_q, busy_d;
  logic              req, pending, ack;
  if (BANKS > 1) begin : g_bank
    assign bank_in = ADDR_IN[BANK_LSB+BANK_W-1:BANK_LSB];
  end else begin : g_nobank
    assign bank_in = '0;
  end
  assign req = ~CS & ~AS & (~UDS | ~LDS);
  // refresh wins a tie with a CPU request; the request stays on the bus and is served later
  assign ack = state_q == IDLE && pending;
  dram_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .ack     (ack),
    .pending (pending)
  );
  // outputs are computed for the state being left and registered, so each phase
  // appears on the pins one clock after the FSM reaches it; AS high abandons the access
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    row_d   = row_q;
    col_d   = col_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    ras_d   = '1;
    cas0_d  = 1'b1;
    cas1_d  = 1'b1;
    we_d    = 1'b1;
    dtack_d = 1'b1;
    busy_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending) begin
          state_d = REF_CAS;
        end else if (req) begin
          state_d = ROW;
          bank_d  = bank_in;
          row_d   = ADDR_IN[ROW_LSB+MA_W-1:ROW_LSB];
          col_d   = ADDR_IN[COL_LSB+MA_W-1:COL_LSB];
          rw_d    = RW;
        end
      end
      ROW: begin
        state_d       = AS ? PRE : COL;
        addr_d        = AS ? addr_q : row_q;
        ras_d[bank_q] = AS;
      end
      COL: begin
        state_d       = AS ? PRE : ACK;
        addr_d        = AS ? addr_q : col_q;
        ras_d[bank_q] = AS;
        we_d          = AS | rw_q;
      end
      ACK: begin
        state_d       = AS ? PRE : ACK;
        ras_d[bank_q] = AS;
        we_d          = AS | rw_q;
        cas1_d        = AS | UDS;
        cas0_d        = AS | LDS;
        dtack_d       = AS;
      end
      REF_CAS: begin
        state_d = REF_RAS;
        cas0_d  = 1'b0;
        cas1_d  = 1'b0;
        busy_d  = 1'b1;
      end
      REF_RAS: begin
        state_d = cnt_q == CNT_W'(RAS_CYCLES - 1) ? PRE : REF_RAS;
        ras_d   = '0;
        cas0_d  = 1'b0;
        cas1_d  = 1'b0;
        busy_d  = 1'b1;
      end
      PRE: state_d = cnt_q == CNT_W'(PRECHARGE_CYCLES - 1) ? IDLE : PRE;
      default: state_d = IDLE;
    endcase
    cnt_d = state_d == state_q ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      ras_q   <= '1;
      cas0_q  <= 1'b1;
      cas1_q  <= 1'b1;
      we_q    <= 1'b1;
      dtack_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      ras_q   <= ras_d;
      cas0_q  <= cas0_d;
      cas1_q  <= cas1_d;
      we_q    <= we_d;
      dtack_q <= dtack_d;
      busy_q  <= busy_d;
    end
  end
  assign ADDR_OUT     = addr_q;
  assign RAS          = ras_q;
  assign CAS0         = cas0_q;
  assign CAS1         = cas1_q;
  assign WE           = we_q;
  assign DTACK_DRAM   = dtack_q;
  assign REFRESH_BUSY = busy_q;
endmodule

// File: tb/tb_dram_controller_banked.sv
// tb_dram_controller_banked: directed stimulus with a scoreboard for CPU accesses and refresh sequences
module tb_dram_controller_banked;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CS = 1'b1, AS = 1'b1, UDS = 1'b1, LDS = 1'b1, RW = 1'b1;
  logic [23:1] ADDR_IN = '0;
  logic [10:0] ADDR_OUT;
  logic [1:0]  RAS;
  logic        CAS0, CAS1, WE, DTACK_DRAM, REFRESH_BUSY;
  int          cyc = 0, checks = 0, passed = 0;
  typedef struct {
    logic [1:0]  ras;
    logic [10:0] row;
    logic [10:0] col;
    logic        we;
    logic        cas1;
    logic        cas0;
    int          at;
  } exp_t;
  exp_t exp_q[$];
  int   ref_q[$];

  dram_controller_banked dut (
    .CLK(CLK), .RST(RST), .CS(CS), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW),
    .ADDR_IN(ADDR_IN), .ADDR_OUT(ADDR_OUT), .RAS(RAS), .CAS0(CAS0), .CAS1(CAS1),
    .WE(WE), .DTACK_DRAM(DTACK_DRAM), .REFRESH_BUSY(REFRESH_BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, want %0h (cyc %0d)", name, act, req, cyc);
  endtask

  // called at a negedge; the request is sampled on the next edge
  task automatic start(input logic [23:0] ba, input logic rw, input logic uds, input logic lds,
                       input logic [1:0] ras, input logic [10:0] row, input logic [10:0] col,
                       input int lat);
    exp_t e;
    ADDR_IN = ba[23:1];
    RW = rw; UDS = uds; LDS = lds; CS = 1'b0; AS = 1'b0;
    e.ras = ras; e.row = row; e.col = col; e.we = rw; e.cas1 = uds; e.cas0 = lds;
    e.at = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_dtack();
    int n = 0;
    while (DTACK_DRAM !== 1'b0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (DTACK_DRAM !== 1'b0) check("dtack_timeout", DTACK_DRAM, 0);
  endtask

  task automatic end_cycle();
    AS = 1'b1; CS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      check("pre_high", {RAS, CAS0, CAS1, WE, DTACK_DRAM}, 6'h3F);
    end
  endtask

  // monitor: captures row/column phases and pops expectations on DTACK fall or refresh start
  initial begin
    logic [1:0]  prev_ras = 2'b11, cap_ras = 2'b11;
    logic [10:0] cap_row = '0, cap_col = '0;
    logic        prev_dtack = 1'b1, cap_we = 1'b1, col_next = 1'b0;
    int          rph = 0;
    exp_t        e;
    forever begin
      @(negedge CLK);
      if (RAS != 2'b11 && prev_ras == 2'b11 && CAS0 && CAS1) begin
        cap_ras = RAS; cap_row = ADDR_OUT; col_next = 1'b1;
      end else if (col_next) begin
        cap_col = ADDR_OUT; cap_we = WE; col_next = 1'b0;
      end
      if (!DTACK_DRAM && prev_dtack) begin
        if (exp_q.size() == 0) check("dtack_unexpected", DTACK_DRAM, 1);
        else begin
          e = exp_q.pop_front();
          check("acc_fields", {cap_ras, cap_row, cap_col, cap_we, CAS1, CAS0},
                {e.ras, e.row, e.col, e.we, e.cas1, e.cas0});
          check("acc_time", cyc, e.at);
        end
      end
      if (rph != 0) begin
        if (rph < 3) check("ref_ras_low", {RAS, CAS0, CAS1, REFRESH_BUSY}, 5'b00001);
        else check("ref_end", {RAS, CAS0, CAS1, REFRESH_BUSY}, 5'b11110);
        rph = rph == 3 ? 0 : rph + 1;
      end else if (!CAS0 && !CAS1 && RAS == 2'b11) begin
        check("ref_busy", REFRESH_BUSY, 1);
        if (ref_q.size() == 0) check("ref_unexpected", cyc, 0);
        else check("ref_time", cyc, ref_q.pop_front());
        rph = 1;
      end
      prev_ras = RAS;
      prev_dtack = DTACK_DRAM;
    end
  end

  initial begin
    repeat (4) @(negedge CLK);
    check("rst_ras", RAS, 2'b11);
    check("rst_cas0", CAS0, 1);
    check("rst_cas1", CAS1, 1);
    check("rst_we", WE, 1);
    check("rst_dtack", DTACK_DRAM, 1);
    check("rst_addr", ADDR_OUT, 0);
    check("rst_busy", REFRESH_BUSY, 0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    start(24'h120034, 1'b1, 1'b0, 1'b0, 2'b10, 11'h120, 11'h01A, 4);
    wait_dtack();
    end_cycle();
    repeat (5) @(negedge CLK);
    start(24'h800010, 1'b0, 1'b1, 1'b0, 2'b01, 11'h000, 11'h008, 4);
    wait_dtack();
    check("wr_we", WE, 0);
    end_cycle();
    repeat (5) @(negedge CLK);
    start(24'hFFFFFE, 1'b1, 1'b0, 1'b0, 2'b01, 11'h7FF, 11'h7FF, 4);
    wait_dtack();
    end_cycle();
    repeat (5) @(negedge CLK);
    ADDR_IN = 23'h000100; RW = 1'b1; UDS = 1'b0; LDS = 1'b0; CS = 1'b0; AS = 1'b0;
    repeat (2) @(negedge CLK);
    check("abort_ras", RAS, 2'b10);
    AS = 1'b1; CS = 1'b1; UDS = 1'b1; LDS = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("abort_high", {RAS, CAS0, CAS1, WE, DTACK_DRAM}, 6'h3F);
    end
    ref_q.push_back(301);
    ref_q.push_back(601);
    ref_q.push_back(901);
    while (cyc != 899) @(negedge CLK);
    start(24'h120034, 1'b1, 1'b0, 1'b0, 2'b10, 11'h120, 11'h01A, 10);
    wait_dtack();
    end_cycle();
    repeat (5) @(negedge CLK);
    start(24'h000002, 1'b1, 1'b0, 1'b0, 2'b10, 11'h000, 11'h001, 4);
    wait_dtack();
    RST = 1'b1;
    @(negedge CLK);
    check("rst_ack", {RAS, CAS0, CAS1, WE, DTACK_DRAM, REFRESH_BUSY, ADDR_OUT},
          {2'b11, 4'b1111, 1'b0, 11'h000});
    AS = 1'b1; CS = 1'b1; UDS = 1'b1; LDS = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    start(24'h7FFFFE, 1'b1, 1'b0, 1'b0, 2'b10, 11'h7FF, 11'h7FF, 4);
    wait_dtack();
    end_cycle();
    repeat (5) @(negedge CLK);
    check("acc_queue_empty", exp_q.size(), 0);
    check("ref_queue_empty", ref_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
